// File: rtl/msxbus_host_seq.sv
// MSX link host sequencer: turns one request into a framed LCS/LCLK beat sequence
// (command, address, data, ack poll, optional fetch) and returns a single response.
module msxbus_host_seq #(
  parameter int unsigned HALF      = 2,
  parameter int unsigned TMO_BEATS = 255,
  parameter int unsigned CS_GAP    = 4
) (
  input  logic        PCLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [3:0]  REQ_CMD,
  input  logic        REQ_SLOT,
  input  logic        REQ_M1,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_DATA,
  output logic [1:0]  RSP_ERR,
  output logic        BUSY,
  output logic        LCS,
  output logic        LCLK,
  output logic [7:0]  LDOUT,
  output logic        LOE,
  input  logic [7:0]  LDIN
);

  localparam int unsigned PH_W  = $clog2(2 * HALF);
  localparam int unsigned GAP_W = $clog2(CS_GAP + 2);

  localparam logic [PH_W-1:0]  PH_FALL  = PH_W'(HALF - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * HALF - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [7:0]       TMO      = 8'(TMO_BEATS);

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_TMO = 2'b01;
  localparam logic [1:0] ERR_CMD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SEND,
    S_POLL,
    S_FETCH,
    S_FINISH,
    S_CS_HOLD
  } state_t;

  typedef struct packed {
    logic [3:0]  cmd;
    logic        slot;
    logic        m1;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  state_t            state;
  req_t              req_q;
  logic [PH_W-1:0]   ph;
  logic [1:0]        beat;
  logic [7:0]        pcnt;
  logic [GAP_W-1:0]  gcnt;
  logic              ready_q;

  logic              short_cmd;
  logic [1:0]        send_last;
  logic [1:0]        last_drv;
  logic [7:0]        cmd_byte;
  logic [7:0]        next_byte;
  logic [7:0]        pcnt_nxt;
  logic              beat_end;
  logic              beat_fall;

  function automatic logic cmd_known(input logic [3:0] c);
    logic ok;
    case (c)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign REQ_READY = ready_q && !RESET;

  // Per-transaction decode of the latched request and beat position.
  always_comb begin
    short_cmd = (req_q.cmd == 4'd5) || (req_q.cmd == 4'd8);
    send_last = short_cmd ? 2'd1 : 2'd3;
    last_drv  = short_cmd ? 2'd0 : 2'd3;
    cmd_byte  = {~req_q.m1, 2'b00, req_q.slot, req_q.cmd};
    pcnt_nxt  = pcnt + 8'd1;
    beat_end  = (ph == PH_LAST);
    beat_fall = (ph == PH_FALL);
    case (beat)
      2'd0:    next_byte = req_q.addr[7:0];
      2'd1:    next_byte = req_q.addr[15:8];
      default: next_byte = req_q.wdata;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      req_q     <= '0;
      ph        <= '0;
      beat      <= '0;
      pcnt      <= '0;
      gcnt      <= '0;
      ready_q   <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= 8'h00;
      RSP_ERR   <= ERR_OK;
      BUSY      <= 1'b0;
      LCS       <= 1'b1;
      LCLK      <= 1'b1;
      LDOUT     <= 8'h00;
      LOE       <= 1'b0;
    end else begin
      RSP_VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (REQ_VALID && ready_q) begin
            if (cmd_known(REQ_CMD)) begin
              req_q   <= '{cmd: REQ_CMD, slot: REQ_SLOT, m1: REQ_M1,
                           addr: REQ_ADDR, wdata: REQ_WDATA};
              state   <= S_CS_SETUP;
              LCS     <= 1'b0;
              BUSY    <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              // Unknown command: answered immediately, link untouched.
              RSP_VALID <= 1'b1;
              RSP_DATA  <= 8'hFF;
              RSP_ERR   <= ERR_CMD;
            end
          end
        end

        S_CS_SETUP: begin
          state <= S_SEND;
          ph    <= '0;
          beat  <= '0;
          LCLK  <= 1'b1;
          LOE   <= 1'b1;
          LDOUT <= cmd_byte;
        end

        S_SEND: begin
          if (beat_end) begin
            if (beat == send_last) begin
              if (short_cmd) begin
                state     <= S_FINISH;
                LCS       <= 1'b1;
                LCLK      <= 1'b1;
                LOE       <= 1'b0;
                RSP_VALID <= 1'b1;
                RSP_DATA  <= (req_q.cmd == 4'd8) ? LDIN : 8'h00;
                RSP_ERR   <= ERR_OK;
              end else begin
                state <= S_POLL;
                ph    <= '0;
                pcnt  <= '0;
                LCLK  <= 1'b1;
              end
            end else begin
              beat <= beat + 2'd1;
              ph   <= '0;
              LCLK <= 1'b1;
              if (!short_cmd) begin
                LOE   <= 1'b1;
                LDOUT <= next_byte;
              end
            end
          end else begin
            ph <= ph + PH_W'(1);
            if (beat_fall) begin
              LCLK <= 1'b0;
              // Release the bus as the slave samples the final driven byte.
              if (beat == last_drv) LOE <= 1'b0;
            end
          end
        end

        S_POLL: begin
          if (beat_end) begin
            if (LDIN == 8'hFF) begin
              if (req_q.cmd[0]) begin
                state <= S_FETCH;
                ph    <= '0;
                LCLK  <= 1'b1;
              end else begin
                state     <= S_FINISH;
                LCS       <= 1'b1;
                LCLK      <= 1'b1;
                RSP_VALID <= 1'b1;
                RSP_DATA  <= 8'hFF;
                RSP_ERR   <= ERR_OK;
              end
            end else if (pcnt_nxt == TMO) begin
              state     <= S_FINISH;
              pcnt      <= pcnt_nxt;
              LCS       <= 1'b1;
              LCLK      <= 1'b1;
              RSP_VALID <= 1'b1;
              RSP_DATA  <= 8'hFF;
              RSP_ERR   <= ERR_TMO;
            end else begin
              pcnt <= pcnt_nxt;
              ph   <= '0;
              LCLK <= 1'b1;
            end
          end else begin
            ph <= ph + PH_W'(1);
            if (beat_fall) LCLK <= 1'b0;
          end
        end

        S_FETCH: begin
          if (beat_end) begin
            state     <= S_FINISH;
            LCS       <= 1'b1;
            LCLK      <= 1'b1;
            RSP_VALID <= 1'b1;
            RSP_DATA  <= LDIN;
            RSP_ERR   <= ERR_OK;
          end else begin
            ph <= ph + PH_W'(1);
            if (beat_fall) LCLK <= 1'b0;
          end
        end

        S_FINISH: begin
          gcnt <= '0;
          if (CS_GAP == 0) begin
            state   <= S_IDLE;
            BUSY    <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            state <= S_CS_HOLD;
          end
        end

        S_CS_HOLD: begin
          if (gcnt == GAP_LAST) begin
            state   <= S_IDLE;
            BUSY    <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            gcnt <= gcnt + GAP_W'(1);
          end
        end

        default: begin
          state   <= S_IDLE;
          LCS     <= 1'b1;
          LCLK    <= 1'b1;
          LOE     <= 1'b0;
          BUSY    <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
